// File: rtl/tx_axis_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tx_axis_arbiter_pkg
// Shared constants for the transmit-side AXI-Stream plumbing of the 10G MAC,
// plus a small one-hot to index helper used by the arbiter.
// -----------------------------------------------------------------------------
package tx_axis_arbiter_pkg;

    localparam int unsigned AXIS_DATA_BYTES = 8;
    localparam int unsigned AXIS_DATA_BITS  = AXIS_DATA_BYTES * 8;

    // Largest supported number of arbitrated source ports.
    localparam int unsigned MAX_PORTS = 8;

    // Index of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic int unsigned onehot_to_index(input logic [MAX_PORTS-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tx_axis_arbiter_if.sv
// -----------------------------------------------------------------------------
// tx_axis_arbiter_if
// AXI-Stream bundle carrying LANES independent 64-bit streams side by side.
// Lane p occupies tdata[p*64+63:p*64] and tkeep[p*8+7:p*8].
//   tdata  : LANES*64 payload
//   tkeep  : LANES*8  byte enables
//   tvalid : LANES    per-lane valid
//   tlast  : LANES    per-lane end of frame
//   tready : LANES    per-lane ready (driven by the consumer)
// Modports: master drives payload/valid/last, slave drives ready.
// -----------------------------------------------------------------------------
interface tx_axis_arbiter_if
    import tx_axis_arbiter_pkg::*;
#(
    parameter int unsigned LANES = 1
) ();

    logic [LANES*AXIS_DATA_BITS-1:0]  tdata;
    logic [LANES*AXIS_DATA_BYTES-1:0] tkeep;
    logic [LANES-1:0]                 tvalid;
    logic [LANES-1:0]                 tlast;
    logic [LANES-1:0]                 tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/tx_axis_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker.
//   req        : request vector, one bit per port
//   last_owner : index of the most recent winner (lowest priority next)
//   sel        : one-hot winner, zero when nothing requests
// The search starts at (last_owner+1) mod NUM_PORTS and wraps.
// -----------------------------------------------------------------------------
module rr_select #(
    parameter  int unsigned NUM_PORTS = 4,
    localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_owner,
    output logic [NUM_PORTS-1:0] sel
);

    int unsigned            start;
    logic [2*NUM_PORTS-1:0] req2;
    logic [NUM_PORTS-1:0]   rot_req;
    logic [NUM_PORTS-1:0]   pick;
    logic [2*NUM_PORTS-1:0] pick2;
    logic                   found;

    always_comb begin
        start = '0;
        if (32'(last_owner) < NUM_PORTS - 1) begin
            start = 32'(last_owner) + 1;
        end

        // Rotate so the highest-priority port sits at bit 0.
        req2    = {req, req};
        rot_req = req2[start +: NUM_PORTS];

        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (rot_req[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end

        // Rotate back: bit p of sel is pick[(p - start) mod NUM_PORTS].
        pick2 = {pick, pick};
        sel   = pick2[(NUM_PORTS - start) +: NUM_PORTS];
    end

endmodule

// File: rtl/tx_axis_arbiter.sv
// -----------------------------------------------------------------------------
// tx_axis_arbiter
// Frame-granular round-robin arbiter feeding the single AXI-Stream input of
// the 10G transmit MAC. A source is granted for a whole frame; the grant is
// released when its tlast beat is accepted, and priority then rotates.
//   i_clk   : MAC transmit clock
//   i_reset : synchronous, active-high reset
//   s_axis  : NUM_PORTS source lanes (slave side; at most one tready high)
//   m_axis  : single lane towards the MAC (master side)
//   o_grant : one-hot current owner, zero while arbitrating
//   o_busy  : high while a frame is locked
// Only state, grant and owner are registered; the data path is a
// zero-latency mux from the owner onto the master.
// -----------------------------------------------------------------------------
module tx_axis_arbiter
    import tx_axis_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    tx_axis_arbiter_if.slave      s_axis,
    tx_axis_arbiter_if.master     m_axis,
    output logic [NUM_PORTS-1:0]  o_grant,
    output logic                  o_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {
        ARB,
        LOCK
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     last_owner;
    logic [NUM_PORTS-1:0] sel;
    logic                 xfer_last;

    rr_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_select (
        .req        (s_axis.tvalid),
        .last_owner (last_owner),
        .sel        (sel)
    );

    // While locked, last_owner is the current owner, so it doubles as the
    // mux select.
    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tvalid = '0;
        m_axis.tlast  = '0;
        if (state == LOCK) begin
            m_axis.tdata  = s_axis.tdata[last_owner*AXIS_DATA_BITS +: AXIS_DATA_BITS];
            m_axis.tkeep  = s_axis.tkeep[last_owner*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
            m_axis.tvalid = s_axis.tvalid[last_owner];
            m_axis.tlast  = s_axis.tlast[last_owner];
        end
        // o_grant is zero outside LOCK, so no ready leaks while arbitrating.
        s_axis.tready = o_grant & {NUM_PORTS{m_axis.tready[0]}};
        xfer_last     = (state == LOCK) && m_axis.tvalid[0] && m_axis.tready[0]
                        && m_axis.tlast[0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ARB;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            last_owner <= IDX_W'(NUM_PORTS - 1);
        end else begin
            case (state)
                ARB: begin
                    if (|s_axis.tvalid) begin
                        state      <= LOCK;
                        o_grant    <= sel;
                        o_busy     <= 1'b1;
                        last_owner <= IDX_W'(onehot_to_index(MAX_PORTS'(sel)));
                    end
                end
                LOCK: begin
                    if (xfer_last) begin
                        state   <= ARB;
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ARB;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_axis_arbiter.md
# tx_axis_arbiter

Frame-granular round-robin arbiter that lets NUM_PORTS user AXI-Stream sources share the single `s00_axis` input of the 10G transmit MAC. It grants one source for a whole frame and holds the grant until that frame's tlast beat is accepted by the MAC. It then rotates priority so that no source can starve another. It sits between the user/application logic and the tx MAC, in the `i_clk` domain of the MAC.

## Interface

Parameters:
- NUM_PORTS, 4: number of source ports; legal range 2..8.

Ports:
- i_clk  in  1  MAC transmit clock.
- i_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_PORTS*64  source data; port p occupies bits [p*64+63:p*64].
- s_axis_tkeep  in  NUM_PORTS*8  source byte enables; port p occupies bits [p*8+7:p*8].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of frame.
- s_axis_tready  out  NUM_PORTS  per-port ready; at most one bit is high.
- m_axis_tdata  out  64  data to the MAC.
- m_axis_tkeep  out  8  byte enables to the MAC.
- m_axis_tvalid  out  1  valid to the MAC.
- m_axis_tlast  out  1  end of frame to the MAC.
- m_axis_tready  in  1  ready from the MAC.
- o_grant  out  NUM_PORTS  one-hot current owner; all zeros when no source is granted.
- o_busy  out  1  high while a frame is locked.

## Operation

State machine states are ARB and LOCK.

ARB state:
- All s_axis_tready are 0, m_axis_tvalid is 0 and o_grant is 0.
- If any s_axis_tvalid bit is set, the arbiter selects the first requesting port, searching upward from (last_owner+1) mod NUM_PORTS and wrapping.
- The selected port is registered into grant, and last_owner is updated to that port.
- The next state is LOCK.
- If no port requests, the state stays ARB.

LOCK state:
- The granted port is muxed combinationally onto the master: m_axis_tdata, tkeep, tvalid and tlast equal that port's signals.
- s_axis_tready[grant] equals m_axis_tready. All other ready bits are 0.
- A beat transfers when m_axis_tvalid and m_axis_tready are both high.
- A transfer with m_axis_tlast high returns the state to ARB.
- If the granted source deasserts tvalid mid-frame, the arbiter passes that through unchanged and stays in LOCK until tlast. The MAC itself signals the resulting error. The arbiter never switches owner mid-frame.

Round-robin rules:
- last_owner resets to NUM_PORTS-1, so port 0 wins the first arbitration.
- A port that has just finished a frame has the lowest priority in the next arbitration.
- Requests from non-granted ports are ignored during LOCK. Those ports see tready 0 and must hold their data (standard AXIS behaviour).

Boundary cases:
- Single-beat frame (tvalid and tlast together on the first beat): LOCK lasts until that beat is accepted, then returns to ARB.
- Stall (m_axis_tready low): outputs hold and the state is unchanged.
- A granted port that stops requesting before its first beat is still granted; LOCK waits for its tlast.
- Reset mid-frame: the state returns to ARB and all outputs are forced to 0 from the next cycle. The partial frame is abandoned, and the MAC aborts it because tvalid drops.

## Timing

- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, o_grant=0, o_busy=0, last_owner=NUM_PORTS-1.
- Grant latency: tvalid sampled in ARB on cycle N gives o_grant and m_axis_tvalid high on cycle N+1.
- Data path: combinational mux from the granted port to the master, with 0 cycles of added latency. Only the grant and state are registered.
- Inter-frame gap: after the tlast transfer on cycle N, the state is ARB on N+1 and the next grant appears on N+2. This gives a minimum of 1 idle master cycle between frames; the MAC's own IPG covers this gap.
- o_busy equals (state == LOCK).

## Structure

- The state enum (ARB, LOCK) is local to the block.
- The shared `mac_pkg` adds the constant AXIS_DATA_BYTES = 8 for reuse alongside the encoder package constants.
- One sub-module, `rr_select`, is natural:
  - Parameterised by NUM_PORTS.
  - Inputs: request vector and last_owner index.
  - Output: one-hot selection (a rotate, then a priority encode, then a rotate back).
  - Purely combinational.

## Test plan

- Single port: port 0 sends 8 beats, the last with tkeep=8'h0F, while m_axis_tready is held at 1. Required: o_grant=4'b0001 one cycle after tvalid, all 8 beats bit-exact on the master, m_axis_tlast on beat 8 with tkeep 8'h0F, then ARB.
- Contention: ports 0–3 all request continuously with 2-beat frames. Required: grant order 0,1,2,3,0,… with exactly 1 idle master cycle between frames.
- Stall: randomly toggle m_axis_tready on a 10-beat frame from port 2. Required: no beat is lost or duplicated, and s_axis_tready[2] mirrors m_axis_tready.
- Mid-frame tvalid drop: port 1 drops tvalid for 3 cycles on beat 4. Required: the grant stays 4'b0010, no other port gets tready, and LOCK holds until port 1's tlast.
- Priority after finish: port 3 completes a frame, then ports 3 and 0 request in the same cycle. Required: port 0 is granted.
- Reset mid-frame: assert i_reset on beat 3 of a port 2 frame. Required: the next cycle shows all outputs 0, and the first grant after reset goes to port 0.
